// File: rtl/axis_frame_capture.sv
// rtl/axis_frame_capture.sv - AXI-Stream frame capture sink with tlast framing check and read port
//
// Purpose: synchronises to tlast frame boundaries, captures one FFT_LEN-sample
// frame into RAM on an arm pulse, flags framing errors and exposes the frame
// through a registered random-access read port.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   s_axis_t*          AXI-Stream sink (tdata lanes {im,re}, lane 0 = highest sample)
//   arm                pulse: capture the next whole frame
//   busy / done        SYNC-or-CAPTURE / frame held in RAM
//   tlast_err          sticky framing error (early or missing tlast)
//   frame_cnt          accepted tlast beats since reset, wrapping
//   rd_addr / rd_data  sample read port, 1-cycle latency
//   ramp_err, ramp_err_cnt   only with CAPTURE_RAMP_CHECK_EN: ramp-pattern checker
//
// Optional feature macro: CAPTURE_RAMP_CHECK_EN

module axis_frame_capture #(
    parameter int WIDTH        = 16,
    parameter int SAMP_PER_CLK = 4,
    parameter int FFT_LEN      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [SAMP_PER_CLK*2*WIDTH-1:0] s_axis_tdata,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    input  logic                            arm,
    output logic                            busy,
    output logic                            done,
    output logic                            tlast_err,
    output logic [15:0]                     frame_cnt,
    input  logic [$clog2(FFT_LEN)-1:0]      rd_addr,
    output logic [2*WIDTH-1:0]              rd_data
`ifdef CAPTURE_RAMP_CHECK_EN
    ,
    output logic                            ramp_err,
    output logic [15:0]                     ramp_err_cnt
`endif
);

    localparam int NB = FFT_LEN / SAMP_PER_CLK;
    localparam int BW = $clog2(NB);
    localparam int AW = $clog2(FFT_LEN);
    localparam logic [BW-1:0] LAST_BEAT = BW'(NB - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_CAPTURE, ST_DONE} state_t;

    state_t              r_state, w_next;
    logic                r_tready;
    logic                r_busy, r_done, r_tlast_err;
    logic [15:0]         r_frame_cnt;
    logic [BW-1:0]       r_bcnt, r_wptr;
    logic [2*WIDTH-1:0]  r_ram [FFT_LEN];
    logic [2*WIDTH-1:0]  r_rd_data;
    logic [AW-1:0]       w_waddr [SAMP_PER_CLK];

    logic w_accept, w_early, w_wr_en, w_last_wr, w_arm_ok;

    assign w_accept  = s_axis_tvalid && r_tready;
    // Early tlast is judged by the free-running beat counter, in every state.
    assign w_early   = w_accept && s_axis_tlast && (r_bcnt != LAST_BEAT);
    assign w_wr_en   = w_accept && (r_state == ST_CAPTURE);
    assign w_last_wr = w_wr_en && (r_wptr == LAST_BEAT);
    assign w_arm_ok  = arm && (r_state == ST_IDLE || r_state == ST_DONE);

    assign s_axis_tready = r_tready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign tlast_err     = r_tlast_err;
    assign frame_cnt     = r_frame_cnt;
    assign rd_data       = r_rd_data;

    // Generator lane order: lane 0 carries the highest sample index of the beat.
    always_comb begin
        for (int j = 0; j < SAMP_PER_CLK; j++) begin
            w_waddr[j] = AW'(int'(r_wptr) * SAMP_PER_CLK + (SAMP_PER_CLK - 1 - j));
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                // Stream already sits on a frame boundary: skip SYNC.
                if (arm) w_next = (r_bcnt == '0 && !w_accept) ? ST_CAPTURE : ST_SYNC;
            end
            ST_SYNC: begin
                if (w_accept && s_axis_tlast) w_next = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (w_last_wr) w_next = ST_DONE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_tready    <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tlast_err <= 1'b0;
            r_frame_cnt <= '0;
            r_bcnt      <= '0;
            r_wptr      <= '0;
        end else begin
            r_state  <= w_next;
            r_tready <= 1'b1;
            r_busy   <= (w_next == ST_SYNC) || (w_next == ST_CAPTURE);
            r_done   <= (w_next == ST_DONE);
            if (w_early || (w_last_wr && !s_axis_tlast)) r_tlast_err <= 1'b1;
            if (w_accept && s_axis_tlast) r_frame_cnt <= r_frame_cnt + 16'd1;
            if (w_accept) r_bcnt <= s_axis_tlast ? '0 : r_bcnt + BW'(1);
            // An early tlast inside CAPTURE restarts the frame from sample 0.
            if (r_state != ST_CAPTURE) r_wptr <= '0;
            else if (w_accept) r_wptr <= w_early ? '0 : r_wptr + BW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int j = 0; j < SAMP_PER_CLK; j++) begin
                r_ram[w_waddr[j]] <= s_axis_tdata[j*2*WIDTH +: 2*WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_rd_data <= '0;
        else        r_rd_data <= r_ram[rd_addr];
    end

`ifdef CAPTURE_RAMP_CHECK_EN
    localparam int CW = $clog2(SAMP_PER_CLK + 1);

    logic          r_ramp_err;
    logic [15:0]   r_ramp_err_cnt;
    logic [CW-1:0] w_mis;
    logic [16:0]   w_sum;

    assign ramp_err     = r_ramp_err;
    assign ramp_err_cnt = r_ramp_err_cnt;

    always_comb begin
        w_mis = '0;
        for (int j = 0; j < SAMP_PER_CLK; j++) begin
            if (s_axis_tdata[j*2*WIDTH +: WIDTH] != WIDTH'(w_waddr[j]) ||
                s_axis_tdata[j*2*WIDTH+WIDTH +: WIDTH] != '0) begin
                w_mis = w_mis + CW'(1);
            end
        end
        w_sum = {1'b0, r_ramp_err_cnt} + 17'(w_mis);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ramp_err     <= 1'b0;
            r_ramp_err_cnt <= '0;
        end else if (w_arm_ok) begin
            r_ramp_err     <= 1'b0;
            r_ramp_err_cnt <= '0;
        end else if (w_wr_en && w_mis != '0) begin
            r_ramp_err     <= 1'b1;
            r_ramp_err_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_axis_frame_capture.sv
// tb/tb_axis_frame_capture.sv - scoreboard testbench for axis_frame_capture

module tb_axis_frame_capture;

    localparam int WIDTH = 16;
    localparam int SPC   = 4;
    localparam int FLEN  = 16;

    localparam int K_TREADY = 0;
    localparam int K_BUSY   = 1;
    localparam int K_DONE   = 2;
    localparam int K_TERR   = 3;
    localparam int K_FCNT   = 4;
    localparam int K_RERR   = 5;
    localparam int K_RCNT   = 6;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [SPC*2*WIDTH-1:0]  s_axis_tdata = '0;
    logic                    s_axis_tvalid = 1'b0;
    logic                    s_axis_tready;
    logic                    s_axis_tlast = 1'b0;
    logic                    arm = 1'b0;
    logic                    busy, done, tlast_err;
    logic [15:0]             frame_cnt;
    logic [3:0]              rd_addr = '0;
    logic [31:0]             rd_data;
`ifdef CAPTURE_RAMP_CHECK_EN
    logic                    ramp_err;
    logic [15:0]             ramp_err_cnt;
`endif

    axis_frame_capture #(.WIDTH(WIDTH), .SAMP_PER_CLK(SPC), .FFT_LEN(FLEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .arm           (arm),
        .busy          (busy),
        .done          (done),
        .tlast_err     (tlast_err),
        .frame_cnt     (frame_cnt),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
`ifdef CAPTURE_RAMP_CHECK_EN
        ,
        .ramp_err      (ramp_err),
        .ramp_err_cnt  (ramp_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } st_t;

    st_t         st_q[$];
    logic [31:0] rd_q[$];
    logic        st_go = 1'b0;
    logic        fin_req = 1'b0;
    logic        rd_req = 1'b0;
    logic        rd_req_d = 1'b0;
    logic [3:0]  rd_addr_d = '0;
    int          total = 0;
    int          bad = 0;
    int          fc = 0;

    always @(posedge clk) begin
        rd_req_d  <= rd_req;
        rd_addr_d <= rd_addr;
    end

    function automatic logic [31:0] get_stat(int k);
        case (k)
            K_TREADY: return 32'(s_axis_tready);
            K_BUSY:   return 32'(busy);
            K_DONE:   return 32'(done);
            K_TERR:   return 32'(tlast_err);
            K_FCNT:   return 32'(frame_cnt);
`ifdef CAPTURE_RAMP_CHECK_EN
            K_RERR:   return 32'(ramp_err);
            K_RCNT:   return 32'(ramp_err_cnt);
`endif
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: pops expectations whenever the DUT presents a read result or a status check is due.
    st_t         m_e;
    logic [31:0] m_rd;
    logic [31:0] m_act;
    always @(negedge clk) begin
        if (rd_req_d) begin
            total++;
            if (rd_q.size() == 0) begin
                bad++;
                $display("FAIL rd_underflow addr=%0d actual=%h required=<none>", rd_addr_d, rd_data);
            end else begin
                m_rd = rd_q.pop_front();
                if (rd_data !== m_rd) begin
                    bad++;
                    $display("FAIL rd_data addr=%0d actual=%h required=%h", rd_addr_d, rd_data, m_rd);
                end
            end
        end
        if (st_go) begin
            while (st_q.size() > 0) begin
                m_e   = st_q.pop_front();
                m_act = get_stat(m_e.kind);
                total++;
                if (m_act !== m_e.exp) begin
                    bad++;
                    $display("FAIL %s actual=%0d required=%0d", m_e.name, m_act, m_e.exp);
                end
            end
        end
        if (fin_req) begin
            total++;
            if (rd_q.size() != 0 || st_q.size() != 0) begin
                bad++;
                $display("FAIL leftover actual=%0d required=0", rd_q.size() + st_q.size());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_st(int kind, int exp, string name);
        st_q.push_back('{kind, 32'(exp), name});
    endtask

    task automatic flush();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        arm           = 1'b0;
        st_go         = 1'b1;
        @(negedge clk);
        #1;
        st_go = 1'b0;
        step();
    endtask

    // One beat of the generator pattern: re = addr + off (or 99 at bad_addr), im = imv.
    task automatic send(int b, bit last, int off, int imv, int bad_addr);
        int a;
        int re;
        for (int j = 0; j < SPC; j++) begin
            a  = b * SPC + (SPC - 1 - j);
            re = (a == bad_addr) ? 99 : a + off;
            s_axis_tdata[j*32 +: 32] = {16'(imv), 16'(re)};
        end
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        if (last) fc++;
        step();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
    endtask

    task automatic read_frame(int off, int imv, string tag);
        for (int a = 0; a < FLEN; a++) begin
            rd_addr = 4'(a);
            rd_req  = 1'b1;
            rd_q.push_back({16'(imv), 16'(a + off)});
            step();
        end
        rd_req = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fc    = 0;
        step();
        step();
        step();
        expect_st(K_TREADY, 0, "rst_tready");
        expect_st(K_BUSY,   0, "rst_busy");
        expect_st(K_DONE,   0, "rst_done");
        expect_st(K_TERR,   0, "rst_tlast_err");
        expect_st(K_FCNT,   0, "rst_frame_cnt");
        flush();
        rst_n = 1'b1;
        step();
        expect_st(K_TREADY, 1, "post_rst_tready");
        flush();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        do_reset();

        // Aligned ramp: arm mid-frame, SYNC to the next tlast, capture one frame.
        send(0, 1'b0, 0, 0, -1);
        send(1, 1'b0, 0, 0, -1);
        arm = 1'b1;
        send(2, 1'b0, 0, 0, -1);
        arm = 1'b0;
        expect_st(K_BUSY, 1, "sync_busy");
        expect_st(K_DONE, 0, "sync_done");
        flush();
        send(3, 1'b1, 0, 0, -1);
        for (int b = 0; b < 4; b++) send(b, b == 3, 0, 0, -1);
        expect_st(K_DONE, 1, "ramp_done");
        expect_st(K_BUSY, 0, "ramp_busy");
        expect_st(K_TERR, 0, "ramp_tlast_err");
        expect_st(K_FCNT, fc, "ramp_frame_cnt");
`ifdef CAPTURE_RAMP_CHECK_EN
        expect_st(K_RCNT, 0, "ramp_chk_cnt");
`endif
        flush();
        read_frame(0, 0, "ramp");

        // Early tlast on beat 2 restarts the capture.
        pulse_arm();
        expect_st(K_DONE, 0, "early_arm_done");
        expect_st(K_BUSY, 1, "early_arm_busy");
        flush();
        send(0, 1'b0, 100, 0, -1);
        send(1, 1'b0, 100, 0, -1);
        send(2, 1'b1, 100, 0, -1);
        expect_st(K_TERR, 1, "early_tlast_err");
        expect_st(K_BUSY, 1, "early_busy");
        expect_st(K_DONE, 0, "early_done");
        expect_st(K_FCNT, fc, "early_frame_cnt");
        flush();
        for (int b = 0; b < 3; b++) send(b, 1'b0, 0, 0, -1);
        expect_st(K_DONE, 0, "restart_partial_done");
        flush();
        send(3, 1'b1, 0, 0, -1);
        expect_st(K_DONE, 1, "restart_done");
        flush();
        read_frame(0, 0, "restart");

        // Missing tlast on the last capture beat.
        do_reset();
        pulse_arm();
        for (int b = 0; b < 4; b++) send(b, 1'b0, 'h40, 7, -1);
        expect_st(K_DONE, 1, "miss_done");
        expect_st(K_TERR, 1, "miss_tlast_err");
        expect_st(K_BUSY, 0, "miss_busy");
        expect_st(K_FCNT, 0, "miss_frame_cnt");
        flush();
        read_frame('h40, 7, "miss");

        // tvalid gaps during capture; arm while busy is ignored.
        pulse_arm();
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < ((b == 2) ? 2 : (b == 1) ? 0 : 1); g++) begin
                arm = (b == 0);
                step();
                arm = 1'b0;
            end
            send(b, b == 3, 0, 0, -1);
        end
        expect_st(K_DONE, 1, "gap_done");
        expect_st(K_FCNT, fc, "gap_frame_cnt");
        flush();
        read_frame(0, 0, "gap");

`ifdef CAPTURE_RAMP_CHECK_EN
        // Corrupt sample 5 and check the ramp checker, then clear it with arm.
        pulse_arm();
        for (int b = 0; b < 4; b++) send(b, b == 3, 0, 0, 5);
        expect_st(K_DONE, 1, "rchk_done");
        expect_st(K_RERR, 1, "rchk_err");
        expect_st(K_RCNT, 1, "rchk_cnt");
        flush();
        pulse_arm();
        expect_st(K_RERR, 0, "rchk_clr_err");
        expect_st(K_RCNT, 0, "rchk_clr_cnt");
        expect_st(K_DONE, 0, "rchk_clr_done");
        flush();
`endif

        fin_req = 1'b1;
        @(negedge clk);
        #1;
        fin_req = 1'b0;
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
